// File: rtl/issue_slot_arbiter_40.sv
// Round-robin issue-slot arbiter: picks one of NUM_SLOTS requesters and holds the grant until accepted.
// Optional ISSUE_ARB_PRIO_EN adds a prio_req port that restricts the scan to high-priority requesters.
module issue_slot_arbiter_40 #(
  parameter int NUM_SLOTS = 40,
  parameter int SEL_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] req,
`ifdef ISSUE_ARB_PRIO_EN
  input  logic [NUM_SLOTS-1:0] prio_req,
`endif
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 grant_valid,
  output logic [SEL_W-1:0]     grant_sel,
  output logic [NUM_SLOTS-1:0] grant_onehot
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [SEL_W:0]   NUM_W    = (SEL_W+1)'(NUM_SLOTS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SLOTS - 1);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       grant_sel_q, grant_sel_d;
  logic [NUM_SLOTS-1:0]   grant_onehot_q, grant_onehot_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;

  logic [NUM_SLOTS-1:0]   scan_vec;
  logic [SEL_W:0]         idx;
  logic [SEL_W-1:0]       win;
  logic                   found;
  logic                   load_opp;

`ifdef ISSUE_ARB_PRIO_EN
  assign scan_vec = ((prio_req & req) != '0) ? (prio_req & req) : req;
`else
  assign scan_vec = req;
`endif

  // Rotating scan from ptr+1; explicit wrap at NUM_SLOTS so indices 40..63 are never visited.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      idx = {1'b0, ptr_q} + (SEL_W+1)'(i + 1);
      if (idx >= NUM_W) idx = idx - NUM_W;
      if (!found && scan_vec[idx]) begin
        found = 1'b1;
        win   = idx[SEL_W-1:0];
      end
    end
  end

  assign load_opp = (state_q == IDLE) || out_ready;

  always_comb begin
    state_d        = state_q;
    grant_sel_d    = grant_sel_q;
    grant_onehot_d = grant_onehot_q;
    ptr_d          = ptr_q;
    if (flush) begin
      state_d        = IDLE;
      grant_onehot_d = '0;
    end else if (load_opp) begin
      if (found) begin
        state_d     = HOLD;
        grant_sel_d = win;
        ptr_d       = win;
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
          grant_onehot_d[i] = (win == SEL_W'(i));
      end else begin
        state_d        = IDLE;
        grant_onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_sel_q    <= '0;
      grant_onehot_q <= '0;
      ptr_q          <= LAST_IDX;
    end else begin
      state_q        <= state_d;
      grant_sel_q    <= grant_sel_d;
      grant_onehot_q <= grant_onehot_d;
      ptr_q          <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == HOLD);
  assign grant_sel    = grant_sel_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: doc/issue_slot_arbiter_40.md
ISSUE_SLOT_ARBITER_40 -- requirements
Module: issue_slot_arbiter_40

Interface
REQ-001 Parameter NUM_SLOTS, default 40, number of requesting slots; fixed at 40 for this block.
REQ-002 Parameter SEL_W, default 6, width of the slot index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  40  per-slot request; bit i = slot i has a 35-bit entry ready to issue.
REQ-006 flush  input  1  discard pending grant; synchronous.
REQ-007 out_ready  input  1  consumer accepts the presented grant this cycle.
REQ-008 grant_valid  output  1  a grant is presented.
REQ-009 grant_sel  output  6  registered slot index, drives the select of the 40x35b mux.
REQ-010 grant_onehot  output  40  one-hot copy of grant_sel; all-zero when grant_valid=0.
REQ-011 prio_req  input  40  high-priority request per slot; present only with ISSUE_ARB_PRIO_EN.

Function
REQ-012 Two states: IDLE (grant_valid=0), HOLD (grant_valid=1).
REQ-013 A "load opportunity" exists when state is IDLE, or when state is HOLD with out_ready=1 (handshake completes).
REQ-014 At a load opportunity with req!=0 and flush=0: next edge loads winner into grant_sel, sets grant_onehot, state HOLD.
REQ-015 At a load opportunity with req==0: next edge state IDLE, grant_valid=0.
REQ-016 Winner = first set bit of req scanning upward from (ptr+1) mod 40, wrapping 39->0; ptr itself searched last.
REQ-017 ptr (6-bit, range 0..39) updates to the winner index on the same edge the winner is loaded.
REQ-018 Throughput: handshake and new load in the same cycle; one grant per cycle sustained, no bubble.
REQ-019 In HOLD with out_ready=0: grant_sel, grant_onehot, grant_valid held stable regardless of req changes (no retraction).
REQ-020 flush=1: next edge state IDLE, grant_valid=0, grant_onehot=0; ptr unchanged; flush overrides any load.
REQ-021 grant_sel holds its last value while IDLE; value never exceeds 39.
REQ-022 req bits 40..63 of the index space do not exist; ptr never wraps through 40..63.
REQ-023 Latency req->grant_valid: 1 cycle from IDLE.

Reset
REQ-024 rst_n=0 asynchronously forces: state IDLE, grant_valid=0, grant_sel=0, grant_onehot=0, ptr=39 (first search starts at slot 0).
REQ-025 Reset asserted mid-HOLD drops the grant immediately; no handshake completes in that cycle.
REQ-026 After rst_n deasserts, first load no earlier than the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ISSUE_ARB_PRIO_EN: when defined, prio_req port exists; if (prio_req & req)!=0 the winner is chosen by the REQ-016 scan over (prio_req & req) only, else over req; single shared ptr.
REQ-028 Without ISSUE_ARB_PRIO_EN: prio_req port absent; arbitration purely per REQ-016.

Verification
REQ-029 Reset, req=bit0|bit5, out_ready=1 -> grants 0,5,0,5... one per cycle, grant_valid continuous.
REQ-030 ptr=39 after reset, req=bit39 only -> grant_sel=39; next req=bit0|bit39 -> grant 0 then 39 (wrap).
REQ-031 HOLD on slot 7, out_ready=0 for 4 cycles, req drops to bit12 -> grant_sel stays 7 until out_ready=1, then 12 next cycle.
REQ-032 flush=1 while HOLD on slot 3 with out_ready=1 -> next cycle grant_valid=0, grant_onehot=0; following grant searches from slot 4.
REQ-033 rst_n pulsed low mid-HOLD on slot 20 -> grant_valid=0, grant_sel=0 without clock edge; next req=all-ones -> grant 0.
REQ-034 With ISSUE_ARB_PRIO_EN, req=all-ones, prio_req=bit30 -> grant 30 repeatedly; prio_req=0 -> resumes at 31.
